// File: rtl/sym_pkg.sv
// Shared types and constants for the 2x2 symmetric-multiply datapath (loader and compute checkers).
package sym_pkg;

  parameter int unsigned ELEM_W_DEF     = 8;
  parameter int unsigned FRAME_LEN_FULL = 16;
  parameter int unsigned FRAME_LEN_NOI  = 12;

  // Packed {I00, I01, I10, I11} identity at the default element width.
  parameter logic [4*ELEM_W_DEF-1:0] IDENT_2X2 =
      {ELEM_W_DEF'(1), {(2*ELEM_W_DEF){1'b0}}, ELEM_W_DEF'(1)};

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StHold
  } state_e;

endpackage

// File: rtl/sym_operand_loader_if.sv
// Element stream in and operand-set handshake out for sym_operand_loader.
interface sym_operand_loader_if
  import sym_pkg::*;
#(
  parameter int unsigned ELEM_W = ELEM_W_DEF
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_sof;
  logic [ELEM_W-1:0]     in_data;
  logic                  mat_valid;
  logic                  mat_ready;
  logic [4*ELEM_W-1:0]   A_out;
  logic [4*ELEM_W-1:0]   B_out;
  logic [4*ELEM_W-1:0]   C_out;
  logic [4*ELEM_W-1:0]   I_out;

  modport master (
    output in_valid, in_sof, in_data, mat_ready,
    input  in_ready, mat_valid, A_out, B_out, C_out, I_out
  );

  modport slave (
    input  in_valid, in_sof, in_data, mat_ready,
    output in_ready, mat_valid, A_out, B_out, C_out, I_out
  );

endinterface

// File: rtl/sym_stall_timer.sv
// Stall counter for the loader: clears on every accept, pulses expire after IDLE_TIMEOUT quiet
// cycles while enabled. IDLE_TIMEOUT = 0 disables it.
module sym_stall_timer #(
  parameter int unsigned IDLE_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic accept,
  output logic expire
);

  if (IDLE_TIMEOUT == 0) begin : g_off
    logic unused;
    assign unused = clk ^ rst_n ^ enable ^ accept;
    assign expire = 1'b0;
  end else begin : g_on
    localparam int unsigned CntW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [CntW-1:0] TermCnt = CntW'(IDLE_TIMEOUT - 1);

    logic [CntW-1:0] count_q, count_d;
    logic            hit;

    // count_q holds quiet cycles already seen, so the terminal cycle is the IDLE_TIMEOUT-th one.
    assign hit = enable && !accept && (count_q == TermCnt);

    always_comb begin
      count_d = count_q;
      if (!enable || accept || hit) begin
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count_q <= '0;
      end else begin
        count_q <= count_d;
      end
    end

    assign expire = hit;
  end

endmodule

// File: rtl/sym_operand_loader.sv
// Assembles a serial element stream into packed A/B/C/I operand words for the compute stage.
// Define SYM_AUTO_IDENT_EN for 12-element frames with I_out fixed to the identity matrix.
module sym_operand_loader
  import sym_pkg::*;
#(
  parameter int unsigned ELEM_W       = ELEM_W_DEF,
  parameter int unsigned IDLE_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  sym_operand_loader_if.slave bus,
  output logic              err_resync,
  output logic              err_timeout,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned WordW = 4 * ELEM_W;
`ifdef SYM_AUTO_IDENT_EN
  localparam int unsigned FrameLen = FRAME_LEN_NOI;
  localparam int unsigned NumWords = 3;
  localparam logic [WordW-1:0] IdentWord = {ELEM_W'(1), {(2*ELEM_W){1'b0}}, ELEM_W'(1)};
`else
  localparam int unsigned FrameLen = FRAME_LEN_FULL;
  localparam int unsigned NumWords = 4;
`endif
  localparam logic [3:0] LastIdx = 4'(FrameLen - 1);

  state_e              state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [WordW-1:0]    word_q [NumWords];
  logic [CNT_W-1:0]    cnt_q;
  logic                err_resync_q, err_timeout_q;

  logic                in_ready, mat_valid;
  logic                accept, expire, resync, wr_en, handshake;
  logic [3:0]          wr_idx;
  int unsigned         wr_lsb;

  assign accept    = bus.in_valid && in_ready;
  assign handshake = mat_valid && bus.mat_ready;

  sym_stall_timer #(
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) u_stall_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(state_q == StLoad),
    .accept(accept),
    .expire(expire)
  );

  // A start marker always restarts the frame; a stray element outside a frame is dropped.
  assign resync = accept && (bus.in_sof ? (state_q == StLoad) : (state_q == StIdle));
  assign wr_en  = accept && (bus.in_sof || (state_q == StLoad));
  assign wr_idx = bus.in_sof ? 4'd0 : idx_q;
  assign wr_lsb = ELEM_W * (3 - int'(wr_idx[1:0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (accept && bus.in_sof) begin
          state_d = StLoad;
          idx_d   = 4'd1;
        end
      end
      StLoad: begin
        if (accept) begin
          if (bus.in_sof) begin
            idx_d = 4'd1;
          end else if (idx_q == LastIdx) begin
            state_d = StHold;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else if (expire) begin
          state_d = StIdle;
          idx_d   = '0;
        end
      end
      StHold: begin
        if (handshake) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    mat_valid = 1'b0;
    case (state_q)
      StIdle, StLoad: in_ready  = 1'b1;
      StHold:         mat_valid = 1'b1;
      default:        in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumWords; i++) begin
        word_q[i] <= '0;
      end
    end else if (wr_en) begin
      word_q[wr_idx[3:2]][wr_lsb +: ELEM_W] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      err_resync_q  <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      err_resync_q  <= resync;
      err_timeout_q <= expire;
      if (handshake) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mat_valid = mat_valid;
  assign bus.A_out     = word_q[0];
  assign bus.B_out     = word_q[1];
  assign bus.C_out     = word_q[2];
`ifdef SYM_AUTO_IDENT_EN
  assign bus.I_out     = IdentWord;
`else
  assign bus.I_out     = word_q[3];
`endif
  assign err_resync    = err_resync_q;
  assign err_timeout   = err_timeout_q;
  assign frame_cnt     = cnt_q;

endmodule

// File: tb/tb_sym_operand_loader.sv
// Self-checking bench for sym_operand_loader against a frame-level behavioural model.
module tb_sym_operand_loader;

  localparam int EW = 8;
  localparam int TO = 64;
  localparam int CW = 8;
`ifdef SYM_AUTO_IDENT_EN
  localparam int  FLEN = 12;
  localparam bit  AUTO = 1'b1;
`else
  localparam int  FLEN = 16;
  localparam bit  AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic err_resync, err_timeout;
  logic [CW-1:0] frame_cnt;

  always #5 clk = ~clk;

  sym_operand_loader_if #(.ELEM_W(EW)) bus ();

  sym_operand_loader #(
    .ELEM_W      (EW),
    .IDLE_TIMEOUT(TO),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .err_resync (err_resync),
    .err_timeout(err_timeout),
    .frame_cnt  (frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model: bytes written so far, frame progress, and what the outputs should show.
  logic [7:0] m_bytes [16];
  int         m_fill, m_stall, m_cnt;
  bit         m_loading, m_hold, m_er, m_et;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_bytes[i] = 8'h00;
    m_fill = 0; m_stall = 0; m_cnt = 0;
    m_loading = 0; m_hold = 0; m_er = 0; m_et = 0;
  endfunction

  function automatic void model_edge(bit v, bit s, logic [7:0] d, bit r);
    m_er = 0;
    m_et = 0;
    if (m_hold) begin
      if (r) begin
        m_hold = 0;
        m_cnt  = (m_cnt + 1) % 256;
      end
    end else if (v) begin
      if (s) begin
        if (m_loading) m_er = 1;
        m_loading  = 1;
        m_bytes[0] = d;
        m_fill     = 1;
        m_stall    = 0;
      end else if (!m_loading) begin
        m_er = 1;
      end else begin
        m_bytes[m_fill] = d;
        m_fill++;
        m_stall = 0;
        if (m_fill == FLEN) begin
          m_hold = 1; m_loading = 0; m_fill = 0;
        end
      end
    end else if (m_loading) begin
      m_stall++;
      if (m_stall == TO) begin
        m_loading = 0; m_fill = 0; m_stall = 0; m_et = 1;
      end
    end
  endfunction

  function automatic logic [127:0] exp_words();
    logic [127:0] w;
    for (int k = 0; k < 4; k++) begin
      w[127-32*k -: 32] = {m_bytes[4*k], m_bytes[4*k+1], m_bytes[4*k+2], m_bytes[4*k+3]};
    end
    if (AUTO) w[31:0] = 32'h01000001;
    return w;
  endfunction

  function automatic logic [11:0] exp_status();
    return {!m_hold, m_hold, m_er, m_et, 8'(m_cnt)};
  endfunction

  function automatic logic [11:0] obs_status();
    return {bus.in_ready, bus.mat_valid, err_resync, err_timeout, frame_cnt};
  endfunction

  function automatic logic [127:0] obs_words();
    return {bus.A_out, bus.B_out, bus.C_out, bus.I_out};
  endfunction

  task automatic step(input bit v, input bit s, input logic [7:0] d, input bit r);
    bus.in_valid  = v;
    bus.in_sof    = s;
    bus.in_data   = d;
    bus.mat_ready = r;
    @(posedge clk);
    model_edge(v, s, d, r);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_sof = 0; bus.in_data = '0; bus.mat_ready = 0;
    rst_n = 1'b0;
    model_reset();
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs_status() !== 12'b1000_0000_0000) begin
      errors++; $display("FAIL reset_status got %h want %h", obs_status(), 12'h800);
    end
    checks++;
    if (obs_words() !== exp_words()) begin
      errors++; $display("FAIL reset_words got %h want %h", obs_words(), exp_words());
    end
  endtask

  task automatic test_basic();
    logic [127:0] lit;
    for (int e = 0; e < FLEN; e++) begin
      step(1, e == 0, 8'(e + 1), 1);
      checks++;
      if (obs_status() !== exp_status()) begin
        errors++; $display("FAIL basic_status e=%0d got %h want %h", e, obs_status(), exp_status());
      end
    end
    lit = {32'h01020304, 32'h05060708, 32'h090A0B0C, AUTO ? 32'h01000001 : 32'h0D0E0F10};
    checks++;
    if (bus.mat_valid !== 1'b1 || obs_words() !== lit) begin
      errors++; $display("FAIL basic_words valid=%b got %h want %h", bus.mat_valid, obs_words(), lit);
    end
    step(0, 0, 8'h00, 1);
    checks++;
    if (frame_cnt !== 8'd1 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_cnt got cnt=%0d rdy=%b want cnt=1 rdy=1", frame_cnt, bus.in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] lit;
    lit = {32'h01020304, 32'h05060708, 32'h090A0B0C, AUTO ? 32'h01000001 : 32'h0D0E0F10};
    for (int e = 0; e < FLEN; e++) step(1, e == 0, 8'(e + 1), 0);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.in_ready !== 1'b0 || bus.mat_valid !== 1'b1 || obs_words() !== lit) begin
        errors++;
        $display("FAIL bp_hold c=%0d rdy=%b vld=%b got %h want %h", c, bus.in_ready, bus.mat_valid,
                 obs_words(), lit);
      end
      step(1, $urandom_range(0, 1), 8'($urandom), 0);
    end
    checks++;
    if (obs_status() !== exp_status() || obs_words() !== lit) begin
      errors++; $display("FAIL bp_sixth got %h want %h", obs_status(), exp_status());
    end
    step(0, 0, 8'h00, 1);
    checks++;
    if (bus.in_ready !== 1'b1 || frame_cnt !== 8'd2) begin
      errors++; $display("FAIL bp_release got rdy=%b cnt=%0d want rdy=1 cnt=2", bus.in_ready, frame_cnt);
    end
  endtask

  task automatic test_resync();
    int pulses = 0;
    for (int e = 0; e < 6 + FLEN; e++) begin
      step(1, e == 0 || e == 6, 8'($urandom), 0);
      if (err_resync === 1'b1) pulses++;
      checks++;
      if (obs_status() !== exp_status() || obs_words() !== exp_words()) begin
        errors++;
        $display("FAIL resync_step e=%0d got %h/%h want %h/%h", e, obs_status(), obs_words(),
                 exp_status(), exp_words());
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL resync_pulses got %0d want 1", pulses);
    end
    step(0, 0, 8'h00, 1);
  endtask

  task automatic test_timeout();
    int pulses = 0;
    for (int e = 0; e < 3; e++) step(1, e == 0, 8'($urandom), 1);
    for (int c = 0; c < TO; c++) begin
      step(0, 0, 8'($urandom), 1);
      if (err_timeout === 1'b1) pulses++;
      checks++;
      if (obs_status() !== exp_status()) begin
        errors++; $display("FAIL timeout_step c=%0d got %h want %h", c, obs_status(), exp_status());
      end
    end
    checks++;
    if (pulses !== 1 || err_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_pulse got %0d/%b want 1/1", pulses, err_timeout);
    end
    step(1, 0, 8'h5A, 1);
    checks++;
    if (err_resync !== 1'b1 || err_timeout !== 1'b0 || obs_words() !== exp_words()) begin
      errors++; $display("FAIL timeout_drop got rs=%b to=%b want rs=1 to=0", err_resync, err_timeout);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(0, 2) == 0) step(1, 0, 8'($urandom), 1);
      for (int e = 0; e < FLEN; e++) begin
        int gap = (f == 5 && e == 7) ? TO + 3 : $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          step(0, $urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1));
          checks++;
          if (obs_status() !== exp_status() || obs_words() !== exp_words()) begin
            errors++;
            $display("FAIL rand_gap f=%0d e=%0d got %h/%h want %h/%h", f, e, obs_status(),
                     obs_words(), exp_status(), exp_words());
          end
        end
        step(1, e == 0, 8'($urandom), $urandom_range(0, 1));
        checks++;
        if (obs_status() !== exp_status() || obs_words() !== exp_words()) begin
          errors++;
          $display("FAIL rand_elem f=%0d e=%0d got %h/%h want %h/%h", f, e, obs_status(),
                   obs_words(), exp_status(), exp_words());
        end
      end
      for (int c = 0; c < 4; c++) begin
        step(0, 0, 8'h00, (c == 3) ? 1'b1 : 1'($urandom_range(0, 1)));
        checks++;
        if (obs_status() !== exp_status() || obs_words() !== exp_words()) begin
          errors++;
          $display("FAIL rand_hold f=%0d c=%0d got %h want %h", f, c, obs_status(), exp_status());
        end
      end
    end
  endtask

  task automatic test_reset_hold();
    for (int e = 0; e < FLEN; e++) step(1, e == 0, 8'($urandom), 0);
    checks++;
    if (bus.mat_valid !== 1'b1) begin
      errors++; $display("FAIL rsthold_pre got vld=%b want 1", bus.mat_valid);
    end
    bus.in_valid = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.mat_valid !== 1'b0 || frame_cnt !== 8'd0 || obs_words() !== exp_words()) begin
      errors++;
      $display("FAIL rsthold_async got vld=%b cnt=%0d words=%h want vld=0 cnt=0 words=%h",
               bus.mat_valid, frame_cnt, obs_words(), exp_words());
    end
    #2 rst_n = 1'b1;
    step(0, 0, 8'h00, 0);
    checks++;
    if (obs_status() !== 12'b1000_0000_0000) begin
      errors++; $display("FAIL rsthold_release got %h want %h", obs_status(), 12'h800);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_resync();
    test_timeout();
    test_random();
    test_reset_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sym_operand_loader.md
Name: sym_operand_loader

Overview:
- Upstream feeder for the 2x2 symmetric-multiply compute stage, which computes Cout = alpha*A*B + beta*C*I.
- Accepts a serial stream of 8-bit matrix elements over a valid/ready handshake and assembles the four packed 32-bit operand words A, B, C and I.
- Presents the complete operand set to the compute stage with a valid/ready handshake.
- Detects broken frames (resync, stall timeout) so the compute stage only ever sees complete, aligned operand sets.

Parameters:
- ELEM_W, 8: element width; packed word width is 4*ELEM_W.
- IDLE_TIMEOUT, 64: max cycles in LOAD with no accepted element before the frame is aborted; 0 disables the timeout.
- CNT_W, 8: width of the delivered-frame counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  element valid.
- in_ready  out  1  loader can accept an element.
- in_sof  in  1  start-of-frame marker, qualified by in_valid.
- in_data  in  ELEM_W  element value.
- mat_valid  out  1  A/B/C/I hold a complete operand set.
- mat_ready  in  1  compute stage takes the set.
- A_out, B_out, C_out, I_out  out  4*ELEM_W each  packed {X00,X01,X10,X11}; X00 occupies the MSBs.
- err_resync  out  1  one-cycle pulse: partial frame discarded, or stray element dropped.
- err_timeout  out  1  one-cycle pulse: frame aborted by stall timeout.
- frame_cnt  out  CNT_W  number of frames delivered, wraps modulo 2^CNT_W.

Behaviour:
- Accept rule: an element is accepted on a cycle with in_valid && in_ready.
- Frame format: elements arrive row-major, matrix order A, B, C, I, 16 elements total.
- Element index e (0..15) goes to matrix e/4, position e%4. Position 0 maps to bits [4*ELEM_W-1 : 3*ELEM_W].
- State machine: IDLE, LOAD, HOLD.
  - IDLE: in_ready=1. An accepted element with in_sof=1 is stored as element 0, the index becomes 1, and the FSM goes to LOAD. An accepted element with in_sof=0 is dropped and err_resync pulses.
  - LOAD: in_ready=1. Each accepted element is stored at the current index and the index increments. Accepting the last element moves the FSM to HOLD.
  - LOAD, in_sof=1 on an accepted element: partial data is discarded, this element becomes element 0, the index becomes 1, err_resync pulses, and the FSM stays in LOAD.
  - HOLD: in_ready=0, mat_valid=1, and A/B/C/I_out stay stable. mat_ready=1 completes the handshake: the FSM goes to IDLE, frame_cnt increments, and in_ready is 1 again on the next cycle.
- Latency: mat_valid asserts on the first cycle after the final element is accepted. mat_ready may be held high continuously.
- Timeout: the stall counter clears on every accepted element and counts cycles in LOAD otherwise. When the count equals IDLE_TIMEOUT (nonzero), the FSM goes to IDLE, the index clears, and err_timeout pulses for one cycle. The timeout is not active in IDLE or HOLD.
- Simultaneous events: an accept always takes priority over the timeout on the same cycle.
- Packed registers are updated only in LOAD/IDLE. Stale bytes from an aborted frame stay visible on the outputs but are never flagged valid.
- Reset (asynchronous, at any time, including mid-frame or in HOLD):
  - FSM=IDLE, index=0, in_ready=1 after release.
  - mat_valid=0, A/B/C/I_out=0.
  - err_resync=0, err_timeout=0, frame_cnt=0.

Optional Feature:
- Macro: SYM_AUTO_IDENT_EN.
- When defined:
  - The frame carries only A, B and C (12 elements), and the last element is index 11.
  - I_out is driven internally as the identity matrix: I00=I11=1, I01=I10=0, giving 32'h01000001 for ELEM_W=8.
  - I_out holds this value from reset onward.
- When not defined: 16-element frames, and I_out is loaded from the stream.

Decomposition:
- Shared package sym_pkg:
  - ELEM_W default.
  - FSM state typedef {IDLE, LOAD, HOLD}.
  - Frame length constants FRAME_LEN_FULL=16 and FRAME_LEN_NOI=12.
  - Identity constant IDENT_2X2 used by this loader and by compute-stage checkers.
- One natural sub-module: sym_stall_timer, containing the clear-on-accept stall counter and the terminal-count pulse, parameterised by IDLE_TIMEOUT.

Test Plan:
- Basic frame: stream 01..10 hex with in_sof on the first element, mat_ready=1.
  - Response: mat_valid one cycle after the 16th accept; A_out=01020304, B_out=05060708, C_out=090A0B0C, I_out=0D0E0F10; frame_cnt=1.
- Backpressure: same frame with mat_ready=0 for 5 cycles.
  - Response: in_ready=0 and outputs stable for all 5 cycles; handshake on the 6th cycle; in_ready=1 on the next cycle.
- Resync: in_sof on element 0, then in_sof again on element 6.
  - Response: err_resync pulses once; a following 16-element frame (starting at the second in_sof element) delivers correctly packed words.
- Timeout: 3 elements, then in_valid=0 for 64 cycles with IDLE_TIMEOUT=64.
  - Response: err_timeout pulses; FSM returns to IDLE; next element without in_sof is dropped and err_resync pulses.
- Reset mid-HOLD: assert rst_n=0 while mat_valid=1.
  - Response: mat_valid=0, outputs 0, frame_cnt=0 immediately (asynchronous); in_ready=1 after release.
- SYM_AUTO_IDENT_EN build: 12-element frame.
  - Response: mat_valid after the 12th accept; I_out=01000001.
